// File: rtl/puf_crp_sequencer_pkg.sv
// Shared definitions for the arbiter-PUF challenge/response sequencer.
// Holds the FSM state type, the LFSR constants and the Galois step helper.
package puf_pkg;

  localparam int C_LENGTH    = 8;
  localparam int SYNC_STAGES = 2;

  localparam logic [C_LENGTH-1:0] LFSR_TAPS     = 8'hB8;
  localparam logic [C_LENGTH-1:0] LFSR_ZERO_SUB = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ARM    = 3'd2,
    S_FIRE   = 3'd3,
    S_HOLD   = 3'd4,
    S_DECIDE = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  // Right-shifting Galois step: the bit shifted out selects the tap mask.
  function automatic logic [C_LENGTH-1:0] lfsr_next(input logic [C_LENGTH-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : {C_LENGTH{1'b0}});
  endfunction

endpackage

// File: rtl/puf_crp_sequencer_if.sv
// Host-side handshake of the PUF sequencer: start/seed in, packed response out.
interface puf_crp_sequencer_if #(
  parameter int RESP_BITS = 16
);
  import puf_pkg::*;

  logic                 start;
  logic [C_LENGTH-1:0]  seed;
  logic                 busy;
  logic [RESP_BITS-1:0] resp_data;
  logic                 resp_valid;
  logic                 resp_ready;

  modport master (
    output start, seed, resp_ready,
    input  busy, resp_data, resp_valid
  );

  modport slave (
    input  start, seed, resp_ready,
    output busy, resp_data, resp_valid
  );

endinterface

// File: rtl/puf_crp_sequencer_lfsr.sv
// 8-bit Galois challenge LFSR with load, step and all-zero seed substitution.
module puf_lfsr8
  import puf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                step,
  input  logic [C_LENGTH-1:0] seed,
  output logic [C_LENGTH-1:0] state
);

  logic [C_LENGTH-1:0] state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
    end else if (load) begin
      // An all-zero seed would lock the LFSR, so it is replaced.
      state_reg <= (seed == '0) ? LFSR_ZERO_SUB : seed;
    end else if (step) begin
      state_reg <= lfsr_next(state_reg);
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/puf_crp_sequencer.sv
// Drives challenges and race pulses into the arbiter PUF, majority-votes the
// synchronised responses and returns a packed word over valid/ready.
module puf_crp_sequencer
  import puf_pkg::*;
#(
  parameter int RESP_BITS = 16,
  parameter int VOTES     = 5,
  parameter int SETTLE    = 4,
  parameter int PULSE_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  puf_crp_sequencer_if.slave       host,
  input  logic                     puf_response,
  output logic [C_LENGTH-1:0]      puf_challenge,
  output logic                     puf_pulse
);

  localparam int CYC_MAX = (SETTLE > PULSE_W) ? SETTLE : PULSE_W;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int VOTE_W  = $clog2(VOTES + 1);
  localparam int BIT_W   = $clog2(RESP_BITS + 1);

  localparam logic [CYC_W-1:0]  SETTLE_LAST = CYC_W'(SETTLE - 1);
  localparam logic [CYC_W-1:0]  PULSE_LAST  = CYC_W'(PULSE_W - 1);
  localparam logic [VOTE_W-1:0] VOTES_C     = VOTE_W'(VOTES);
  localparam logic [VOTE_W-1:0] VOTE_HALF   = VOTE_W'(VOTES / 2);
  localparam logic [BIT_W-1:0]  BITS_C      = BIT_W'(RESP_BITS);

  state_e                 state_reg, state_next;
  logic [CYC_W-1:0]       cyc_reg, cyc_next;
  logic [VOTE_W-1:0]      vote_reg, vote_next;
  logic [VOTE_W-1:0]      ones_reg, ones_next;
  logic [BIT_W-1:0]       bit_reg, bit_next;
  logic [RESP_BITS-1:0]   resp_reg, resp_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   lfsr_load;
  logic                   lfsr_step;
  logic                   sample;

  puf_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (host.seed),
    .state (puf_challenge)
  );

  // The arbiter output is asynchronous to clk; only the last stage is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], puf_response};
    end
  end

  assign sample = sync_reg[SYNC_STAGES-1];

  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    vote_next  = vote_reg;
    ones_next  = ones_reg;
    bit_next   = bit_reg;
    resp_next  = resp_reg;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (host.start) begin
          lfsr_load  = 1'b1;
          state_next = S_LOAD;
        end
      end

      S_LOAD: begin
        cyc_next   = '0;
        vote_next  = '0;
        ones_next  = '0;
        bit_next   = '0;
        resp_next  = '0;
        state_next = S_ARM;
      end

      S_ARM: begin
        if (cyc_reg == SETTLE_LAST) begin
          cyc_next   = '0;
          state_next = S_FIRE;
        end else begin
          cyc_next = cyc_reg + CYC_W'(1);
        end
      end

      S_FIRE: begin
        if (cyc_reg == PULSE_LAST) begin
          cyc_next   = '0;
          state_next = S_HOLD;
        end else begin
          cyc_next = cyc_reg + CYC_W'(1);
        end
      end

      S_HOLD: begin
        if (cyc_reg == SETTLE_LAST) begin
          // The race has had SETTLE cycles plus sync latency to resolve.
          cyc_next   = '0;
          ones_next  = ones_reg + VOTE_W'(sample);
          vote_next  = vote_reg + VOTE_W'(1);
          state_next = (vote_reg + VOTE_W'(1) == VOTES_C) ? S_DECIDE : S_ARM;
        end else begin
          cyc_next = cyc_reg + CYC_W'(1);
        end
      end

      S_DECIDE: begin
        // First voted bit ends up in the MSB once the word is complete.
        resp_next  = {resp_reg[RESP_BITS-2:0], (ones_reg > VOTE_HALF)};
        lfsr_step  = 1'b1;
        ones_next  = '0;
        vote_next  = '0;
        bit_next   = bit_reg + BIT_W'(1);
        state_next = (bit_reg + BIT_W'(1) == BITS_C) ? S_DONE : S_ARM;
      end

      S_DONE: begin
        if (host.resp_ready) begin
          state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cyc_reg   <= '0;
      vote_reg  <= '0;
      ones_reg  <= '0;
      bit_reg   <= '0;
      resp_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      vote_reg  <= vote_next;
      ones_reg  <= ones_next;
      bit_reg   <= bit_next;
      resp_reg  <= resp_next;
    end
  end

  // Decoded straight from the state register so reset clears them at once.
  assign puf_pulse       = (state_reg == S_FIRE);
  assign host.busy       = (state_reg != S_IDLE);
  assign host.resp_valid = (state_reg == S_DONE);
  assign host.resp_data  = resp_reg;

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Scoreboard bench for puf_crp_sequencer: a PUF response model drives the
// arbiter input, expected words are queued at start and popped on resp_valid.
module tb_puf_crp_sequencer;
  import puf_pkg::*;

  localparam int RB  = 16;
  localparam int V   = 5;
  localparam int S   = 4;
  localparam int P   = 2;
  localparam int LAT = 817;

  localparam int M_STUCK  = 0;
  localparam int M_NOISY  = 1;
  localparam int M_PARITY = 2;
  localparam int M_RAND   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       puf_response = 1'b0;
  logic [7:0] puf_challenge;
  logic       puf_pulse;

  puf_crp_sequencer_if #(.RESP_BITS(RB)) host ();

  puf_crp_sequencer #(
    .RESP_BITS (RB),
    .VOTES     (V),
    .SETTLE    (S),
    .PULSE_W   (P)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host          (host),
    .puf_response  (puf_response),
    .puf_challenge (puf_challenge),
    .puf_pulse     (puf_pulse)
  );

  always #5 clk = ~clk;

  int      n_checks = 0;
  int      n_fail = 0;
  longint  cyc = 0;
  longint  accept_cyc = 0;
  int      mode = M_STUCK;
  logic    pat [RB][V];
  logic [7:0]    exp_chal [RB];
  logic [RB-1:0] exp_q [$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // PUF model plus pulse/challenge monitor
  int         eval_idx = 0;
  int         hi_len = 0;
  int         hold_left = 0;
  logic       pulse_d = 1'b0;
  longint     last_rise = 0;
  logic [7:0] chal_at_rise = 8'h00;

  always @(posedge clk) begin
    #1;
    if (!host.busy) begin
      eval_idx  = 0;
      pulse_d   = 1'b0;
      hold_left = 0;
    end else begin
      if (puf_pulse && !pulse_d) begin
        int b;
        int k;
        b = eval_idx / V;
        k = eval_idx % V;
        if (b >= RB) begin
          check("extra_pulse", 32'(b), 32'(RB - 1));
        end else begin
          check("challenge", 32'(puf_challenge), 32'(exp_chal[b]));
          if (k != 0) check("pulse_spacing", 32'(cyc - last_rise), 32'(2 * S + P));
          puf_response = (mode == M_PARITY) ? ^puf_challenge : pat[b][k];
        end
        last_rise    = cyc;
        hi_len       = 0;
        chal_at_rise = puf_challenge;
        eval_idx++;
      end
      if (puf_pulse) begin
        hi_len++;
        check("chal_stable_pulse", 32'(puf_challenge), 32'(chal_at_rise));
      end
      if (!puf_pulse && pulse_d) begin
        check("pulse_width", 32'(hi_len), 32'(P));
        hold_left = S;
      end
      if (hold_left > 0) begin
        check("chal_stable_hold", 32'(puf_challenge), 32'(chal_at_rise));
        hold_left--;
      end
      pulse_d = puf_pulse;
    end
  end

  // Result monitor: pops the scoreboard when a word is presented
  logic valid_d = 1'b0;

  always @(posedge clk) begin
    #1;
    if (host.resp_valid && !valid_d) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h, expected no word", host.resp_data);
      end else begin
        logic [RB-1:0] e;
        e = exp_q.pop_front();
        check("resp_data", 32'(host.resp_data), 32'(e));
        check("latency", 32'(cyc - accept_cyc), 32'(LAT));
        $display("word seed-run done: data=%04h expected=%04h latency=%0d", host.resp_data, e, cyc - accept_cyc);
      end
    end
    valid_d = host.resp_valid;
  end

  task automatic run_word(input logic [7:0] seed, input int m, input int bp, input bit abort);
    logic [7:0]    c;
    logic [RB-1:0] w;
    int            n;
    int            ones;

    n = 0;
    while (host.busy && n < 100) begin
      @(posedge clk);
      n++;
    end

    mode = m;
    c = (seed == 8'h00) ? 8'h01 : seed;
    w = '0;
    for (int b = 0; b < RB; b++) begin
      exp_chal[b] = c;
      ones = 0;
      for (int k = 0; k < V; k++) begin
        case (m)
          M_STUCK:  pat[b][k] = 1'b1;
          M_NOISY:  pat[b][k] = (b == 0) ? (k < 2) : (k < 3);
          M_PARITY: pat[b][k] = ^c;
          default:  pat[b][k] = 1'($urandom_range(0, 1));
        endcase
        ones += int'(pat[b][k]);
      end
      w[RB-1-b] = (ones > V / 2);
      c = (c >> 1) ^ (c[0] ? 8'hB8 : 8'h00);
    end
    exp_q.push_back(w);

    @(negedge clk);
    host.start = 1'b1;
    host.seed  = seed;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    check("busy_after_start", 32'(host.busy), 32'd1);
    @(negedge clk);
    host.start = 1'b0;
    host.seed  = 8'($urandom);

    if (abort) begin
      n = 0;
      while (!(puf_pulse && eval_idx > 7 * V) && n < 2000) begin
        @(posedge clk);
        #2;
        n++;
      end
      check("reached_bit7_fire", 32'(puf_pulse), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_pulse", 32'(puf_pulse), 32'd0);
      check("rst_busy", 32'(host.busy), 32'd0);
      check("rst_valid", 32'(host.resp_valid), 32'd0);
      check("rst_challenge", 32'(puf_challenge), 32'd0);
      check("rst_data", 32'(host.resp_data), 32'd0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end

    n = 0;
    while (!host.resp_valid && n < 2000) begin
      @(posedge clk);
      #2;
      check("busy_during_word", 32'(host.busy), 32'd1);
      n++;
    end
    if (!host.resp_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_timeout: got resp_valid=0, expected 1 within 2000 cycles");
    end

    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      host.start = 1'($urandom_range(0, 1));
      host.seed  = 8'($urandom);
      @(posedge clk);
      #2;
      check("bp_valid", 32'(host.resp_valid), 32'd1);
      check("bp_data", 32'(host.resp_data), 32'(w));
    end

    @(negedge clk);
    host.resp_ready = 1'b1;
    host.start      = 1'b1;
    @(posedge clk);
    #2;
    check("exit_valid", 32'(host.resp_valid), 32'd0);
    check("exit_busy", 32'(host.busy), 32'd0);
    @(negedge clk);
    host.resp_ready = 1'b0;
    host.start      = 1'b0;
    @(posedge clk);
    #2;
    check("exit_start_ignored", 32'(host.busy), 32'd0);
  endtask

  initial begin
    host.start      = 1'b0;
    host.seed       = 8'h00;
    host.resp_ready = 1'b0;
    rst_n           = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pulse", 32'(puf_pulse), 32'd0);
    check("reset_challenge", 32'(puf_challenge), 32'd0);
    check("reset_busy", 32'(host.busy), 32'd0);
    check("reset_valid", 32'(host.resp_valid), 32'd0);
    check("reset_data", 32'(host.resp_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_word(8'hA5, M_STUCK, 0, 1'b0);
    run_word(8'h00, M_RAND, 3, 1'b0);
    run_word(8'($urandom), M_NOISY, 50, 1'b0);
    run_word(8'h3C, M_PARITY, 0, 1'b0);
    run_word(8'($urandom), M_RAND, 0, 1'b1);
    run_word(8'h5A, M_PARITY, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_word(8'($urandom), M_RAND, int'($urandom_range(0, 5)), 1'b0);
    end

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL pending_words: got %0d words outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_crp_sequencer.md
Name: puf_crp_sequencer

Overview:
Upstream driver and downstream collector for the 8-stage arbiter PUF core.
- Generates each challenge from an 8-bit LFSR and launches the race pulse.
- Synchronises and samples the arbiter response, majority-votes repeated evaluations, and packs the voted bits into a response word.
- Hands the word to the host over a valid/ready handshake.
- Sits between the tile I/O logic and the PUF core, replacing direct clk-as-pulse drive.

Parameters:
- RESP_BITS, 16, voted response bits per word (2..32)
- VOTES, 5, evaluations per challenge; must be odd, 1..15
- SETTLE, 4, cycles of challenge setup before the pulse and of hold after it; must be >= 3
- PULSE_W, 2, cycles puf_pulse stays high (>= 1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a word; sampled only in IDLE
- seed  in  8  LFSR seed, loaded on accepted start
- puf_response  in  1  arbiter output (asynchronous to clk)
- puf_challenge  out  8  challenge to the PUF mux chain
- puf_pulse  out  1  race pulse into both delay-line inputs
- busy  out  1  high in every state except IDLE
- resp_data  out  RESP_BITS  packed voted response
- resp_valid  out  1  resp_data valid
- resp_ready  in  1  host accepts resp_data

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Async assert of rst_n forces state IDLE and clears LFSR, counters, synchroniser and resp_data to 0.
  - Outputs during and after reset: puf_pulse=0, puf_challenge=0, busy=0, resp_valid=0.
  - Reset mid-word discards all partial results.
- LFSR: 8-bit Galois, right shift, taps mask 0xB8. A seed of 0x00 is replaced by 0x01. It steps once per voted bit, after DECIDE. puf_challenge always equals the LFSR value.
- Synchroniser: puf_response passes through 2 flops before sampling.
- FSM states: IDLE, LOAD, ARM, FIRE, HOLD, DECIDE, DONE.
  - IDLE: waits for start=1.
  - LOAD (1 cycle): loads the LFSR, clears bit_cnt, vote_cnt and ones_cnt.
  - ARM (SETTLE cycles): puf_pulse=0, challenge stable.
  - FIRE (PULSE_W cycles): puf_pulse=1.
  - HOLD (SETTLE cycles): puf_pulse=0. On the last HOLD cycle the synchronised response is sampled and ones_cnt += sample. vote_cnt increments, then the FSM goes back to ARM, or to DECIDE once vote_cnt reaches VOTES.
  - DECIDE (1 cycle): bit = (ones_cnt > VOTES/2). resp_data is shifted left with bit entering the LSB, so the first bit ends up in the MSB. LFSR steps; ones_cnt and vote_cnt clear; bit_cnt increments. Next state is ARM, or DONE when bit_cnt reaches RESP_BITS.
  - DONE: resp_valid=1 and resp_data held stable. resp_ready=1 returns to IDLE the next cycle with resp_valid=0.
- start in any non-IDLE state is ignored (no queueing). start in the same cycle DONE exits is also ignored.
- Latency from the start-accept edge to resp_valid: 1 + RESP_BITS*(VOTES*(2*SETTLE+PULSE_W)+1) cycles. With defaults this is 817.
- Counter widths: ceil(log2(max+1)) of the respective parameter. No wrap is reachable given the parameter ranges.
- puf_challenge never changes while puf_pulse=1 or during HOLD.

Decomposition:
- Shared package puf_pkg holds:
  - state enum
  - LFSR_TAPS=8'hB8
  - LFSR_ZERO_SUB=8'h01
  - challenge width constant C_LENGTH=8
- One sub-module: puf_lfsr8 (load, step, seed-zero substitution, 8-bit state out).

Test Plan:
- Stuck-one model (puf_response=1), seed 0xA5, start pulse → resp_valid rises exactly 817 cycles after accept; resp_data=16'hFFFF; busy high throughout.
- Seed 0x00 → first puf_challenge observed in ARM is 0x01; second challenge equals one Galois step (0xB8). Check 16 challenges against a reference LFSR model.
- Noisy model: 2 of 5 evaluations return 1 for the first bit, 3 of 5 for the rest → resp_data=16'h7FFF.
- Backpressure: hold resp_ready=0 for 50 cycles after valid → resp_valid and resp_data stay stable; start pulses during that window are ignored. resp_ready=1 → IDLE next cycle.
- Parity model (response = ^challenge) with seed 0x3C → resp_data matches a scoreboard built from LFSR challenge parity. Also check pulse width is 2 cycles and pulse spacing is 10 cycles.
- Assert rst_n low mid-FIRE of bit 7 → puf_pulse=0, busy=0, resp_valid=0 immediately (async). After release, a new start produces a correct full word.
